// File: rtl/decode_mac_requant.sv
// decode_mac_requant
// Streaming multiply-accumulate back end for the decoder datapath. Signed
// products arrive one per accepted beat. Every NUM_TERMS products form one
// dot product, which is rounded (half toward +inf), shifted down by
// FRAC_SHIFT, saturated to OUT_WIDTH and presented on a valid/ready output.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   product beat valid
//   in_ready   block accepts a beat this cycle
//   in_prod    signed product, PROD_WIDTH bits
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   signed requantised result, OUT_WIDTH bits
//   out_sat    out_data was clipped to the representable range
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A source holds valid and its data stable until that transfer.
// Ready may depend combinationally on the opposite side's ready
// (in_ready follows out_ready), never on the same side's valid.
//
// Pipeline: S1 accumulator (acc, cnt) -> S2 result register (res, res_valid)
// -> S3 output register (out_data, out_sat, out_valid).
module decode_mac_requant #(
  parameter int PROD_WIDTH = 65,
  parameter int ACC_WIDTH  = 72,
  parameter int NUM_TERMS  = 16,
  parameter int FRAC_SHIFT = 24,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PROD_WIDTH-1:0] in_prod,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);
  // Half an output LSB, added before the shift to round half toward +inf.
  localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH + 1)'(1) <<< (FRAC_SHIFT - 1);

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] res;
  logic [CNT_W-1:0]            cnt;
  logic                        res_valid;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic                        accept;
  logic                        last_beat;
  logic                        move;

  assign prod_ext  = ACC_WIDTH'(in_prod);
  assign acc_sum   = acc + prod_ext;
  assign move      = res_valid && (!out_valid || out_ready);
  // Any beat (last or not) waits while S2 is full and cannot drain.
  assign in_ready  = !res_valid || move;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST_CNT);

  // Requantisation of the S2 result. One extra bit keeps the rounding add
  // from wrapping when res is near the positive limit.
  logic signed [ACC_WIDTH:0]            t_sum;
  logic signed [ACC_WIDTH:0]            t_shr;
  logic [ACC_WIDTH-OUT_WIDTH+1:0]       t_hi;
  logic                                 t_fits;
  logic signed [OUT_WIDTH-1:0]          rq_data;
  logic                                 rq_sat;

  assign t_sum = (ACC_WIDTH + 1)'(res) + RND;
  assign t_shr = t_sum >>> FRAC_SHIFT;
  // The value fits OUT_WIDTH when every bit from the output sign bit up is
  // a copy of the sign.
  assign t_hi   = t_shr[ACC_WIDTH:OUT_WIDTH-1];
  assign t_fits = (&t_hi) || !(|t_hi);

  always_comb begin
    rq_data = t_shr[OUT_WIDTH-1:0];
    rq_sat  = 1'b0;
    if (!t_fits) begin
      rq_sat = 1'b1;
      if (t_shr[ACC_WIDTH]) begin
        rq_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        rq_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end

  // S1 accumulator and S2 result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (last_beat) begin
          res <= acc_sum;
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
      // A new last beat refills S2 in the same cycle it drains.
      if (accept && last_beat) begin
        res_valid <= 1'b1;
      end else if (move) begin
        res_valid <= 1'b0;
      end
    end
  end

  // S3 output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (move) begin
      out_valid <= 1'b1;
      out_data  <= rq_data;
      out_sat   <= rq_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_mac_requant.sv
// Bench for decode_mac_requant with three instances: NUM_TERMS = 4, 1 and 3.
module tb_decode_mac_requant;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst4_x;

  // NUM_TERMS = 4 instance
  logic iv4, ir4, ov4, or4, os4;
  logic signed [64:0] ip4;
  logic signed [31:0] od4;
  // NUM_TERMS = 1 instance
  logic iv1, ir1, ov1, or1, os1;
  logic signed [64:0] ip1;
  logic signed [31:0] od1;
  // NUM_TERMS = 3 instance
  logic iv3, ir3, ov3, or3, os3;
  logic signed [64:0] ip3;
  logic signed [31:0] od3;

  decode_mac_requant #(.NUM_TERMS(4)) u4 (
    .clk(clk), .reset(rst || rst4_x), .in_valid(iv4), .in_ready(ir4), .in_prod(ip4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sat(os4)
  );
  decode_mac_requant #(.NUM_TERMS(1)) u1 (
    .clk(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1), .in_prod(ip1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sat(os1)
  );
  decode_mac_requant #(.NUM_TERMS(3)) u3 (
    .clk(clk), .reset(rst), .in_valid(iv3), .in_ready(ir3), .in_prod(ip3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_sat(os3)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model for the NUM_TERMS=3 random run -------
  localparam int W = 33;           // {sat, data}
  logic [W-1:0]       exp_q[$];
  logic signed [64:0] terms_q[$];
  bit                 mon_en = 1'b0;
  int                 n_out3 = 0;
  bit                 hold3  = 1'b0;
  logic [W-1:0]       prev3;

  // Round half up to an integer after dropping 24 fractional bits, clip to
  // the signed 32-bit range.
  function automatic logic [W-1:0] ref_rq(input logic signed [127:0] s);
    logic signed [127:0] t;
    t = (s + (128'sd1 <<< 23)) >>> 24;
    if (t > 128'sd2147483647)        return {1'b1, 32'h7fffffff};
    else if (t < -128'sd2147483648)  return {1'b1, 32'h80000000};
    else                             return {1'b0, t[31:0]};
  endfunction

  // Inputs only change just after a rising edge, so the negedge view is what
  // the next rising edge will see.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold3) begin
        check("hold_valid", ov3, 1);
        check("hold_data", {os3, od3}, prev3);
      end
      if (!ir3) check("in_ready_low_implies_full_stall", ov3 && !or3, 1);
      if (iv3 && ir3) begin
        terms_q.push_back(ip3);
        if (terms_q.size() == 3) begin
          logic signed [127:0] s;
          s = 0;
          foreach (terms_q[i]) s = s + terms_q[i];
          exp_q.push_back(ref_rq(s));
          terms_q.delete();
        end
      end
      if (ov3 && or3) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("rand_data", od3, $signed(e[31:0]));
          check("rand_sat", os3, e[32]);
          n_out3++;
        end
      end
      hold3 = ov3 && !or3;
      prev3 = {os3, od3};
    end
  end

  function automatic logic signed [64:0] rand_prod();
    logic signed [64:0] r;
    r = 65'({$urandom(), $urandom(), $urandom()});
    r = r >>> $urandom_range(0, 40);
    return r;
  endfunction

  typedef struct {
    logic signed [64:0] prod;
    logic signed [31:0] data;
    logic               sat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  accepted;
    int  cyc;
    bit  fire;

    vecs[0] = '{65'sh800000,   32'sd1,  1'b0};
    vecs[1] = '{65'sh7fffff,   32'sd0,  1'b0};
    vecs[2] = '{-65'sh800000,  32'sd0,  1'b0};
    vecs[3] = '{-65'sh800001, -32'sd1,  1'b0};
    vecs[4] = '{65'sd1 <<< 55, 32'sh7fffffff, 1'b1};
    vecs[5] = '{-(65'sd1 <<< 55) - (65'sd1 <<< 24), 32'sh80000000, 1'b1};
    vecs[6] = '{-(65'sd1 <<< 55), 32'sh80000000, 1'b0};

    rst = 1'b1; rst4_x = 1'b0;
    iv4 = 0; ip4 = '0; or4 = 0;
    iv1 = 0; ip1 = '0; or1 = 0;
    iv3 = 0; ip3 = '0; or3 = 0;
    repeat (3) tick();
    rst = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_ov4", ov4, 0); check("rst_ir4", ir4, 1); check("rst_od4", od4, 0);
    check("rst_ov1", ov1, 0); check("rst_ir1", ir1, 1); check("rst_os1", os1, 0);
    check("rst_ov3", ov3, 0); check("rst_ir3", ir3, 1); check("rst_od3", od3, 0);

    // ---------------- basic sum, NUM_TERMS=4 ----------------
    tick();
    or4 = 1;
    for (int k = 0; k < 4; k++) begin
      iv4 = 1; ip4 = 65'(k + 1) <<< 24;
      @(negedge clk);
      check("basic_in_ready", ir4, 1);
      tick();
    end
    iv4 = 0;
    @(negedge clk);
    check("basic_not_yet", ov4, 0);
    check("basic_in_ready_after", ir4, 1);
    tick();
    @(negedge clk);
    check("basic_valid", ov4, 1);
    check("basic_data", od4, 10);
    check("basic_sat", os4, 0);
    tick();
    @(negedge clk);
    check("basic_drained", ov4, 0);

    // ---------------- rounding / saturation table, NUM_TERMS=1 ------------
    or1 = 1;
    for (int i = 0; i < 7; i++) begin
      iv1 = 1; ip1 = vecs[i].prod;
      tick();
      iv1 = 0;
      @(negedge clk);
      check("tbl_latency", ov1, 0);
      tick();
      @(negedge clk);
      check("tbl_valid", ov1, 1);
      check($sformatf("tbl_data_%0d", i), od1, vecs[i].data);
      check($sformatf("tbl_sat_%0d", i), os1, vecs[i].sat);
    end
    tick();

    // ---------------- backpressure, NUM_TERMS=1 ----------------
    or1 = 0;
    iv1 = 1; ip1 = 65'sd1 <<< 24;
    @(negedge clk); check("bp_ready_c1", ir1, 1);
    tick();
    ip1 = 65'sd2 <<< 24;
    @(negedge clk); check("bp_ready_c2", ir1, 1);
    tick();
    iv1 = 0;
    @(negedge clk);
    check("bp_ready_c3", ir1, 0);
    check("bp_s3_valid", ov1, 1);
    check("bp_s3_data", od1, 1);
    tick();
    @(negedge clk);
    check("bp_ready_c4", ir1, 0);
    check("bp_s3_stable", od1, 1);
    tick();
    or1 = 1;
    @(negedge clk);
    check("bp_ready_rises", ir1, 1);
    check("bp_first_valid", ov1, 1);
    check("bp_first_data", od1, 1);
    tick();
    @(negedge clk);
    check("bp_second_valid", ov1, 1);
    check("bp_second_data", od1, 2);
    tick();
    @(negedge clk);
    check("bp_empty", ov1, 0);

    // ---------------- reset mid-sum, NUM_TERMS=4 ----------------
    tick();
    or4 = 1;
    iv4 = 1; ip4 = 65'sd5 <<< 24;
    tick(); tick();
    iv4 = 0; rst4_x = 1;
    tick();
    rst4_x = 0;
    @(negedge clk);
    check("mid_rst_ov", ov4, 0);
    check("mid_rst_od", od4, 0);
    check("mid_rst_os", os4, 0);
    check("mid_rst_ir", ir4, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      iv4 = 1; ip4 = 65'sd1 <<< 24;
      tick();
    end
    iv4 = 0;
    @(negedge clk); check("mid_no_early", ov4, 0);
    tick();
    @(negedge clk);
    check("mid_valid", ov4, 1);
    check("mid_data", od4, 4);
    tick();
    @(negedge clk); check("mid_single", ov4, 0);

    // ---------------- random, NUM_TERMS=3 ----------------
    tick();
    mon_en   = 1'b1;
    accepted = 0;
    cyc      = 0;
    fire     = 1'b0;
    while (accepted < 1000 && cyc < 20000) begin
      if (fire) begin
        accepted++;
        iv3 = 0;
      end
      if (accepted < 1000) begin
        or3 = ($urandom_range(0, 3) != 0);
        if (!iv3 && $urandom_range(0, 3) != 0) begin
          iv3 = 1;
          ip3 = rand_prod();
        end
        @(negedge clk);
        fire = iv3 && ir3;
        tick();
        cyc++;
      end
    end
    iv3 = 0;
    or3 = 1;
    cyc = 0;
    while ((exp_q.size() != 0 || ov3) && cyc < 100) begin
      tick();
      cyc++;
    end
    @(negedge clk);
    check("rand_accepted", accepted, 1000);
    check("rand_drain_in_time", cyc < 100, 1);
    check("rand_result_count", n_out3, 333);
    check("rand_queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
